// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves memory-wait stalls, branch flushes
// and load-use hazards, with saturating performance counters and a wait watchdog.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64,
  parameter int WAIT_W   = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_q, stall_d, flush_q, flush_d;
  logic                hazard;
  logic                pipe_go;
  logic                flush_evt;

  // Register x0 is hard-wired to zero, so a load targeting it never stalls.
  assign hazard = ex_memread && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  assign wait_inc = wait_q + 1'b1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    pipe_go      = 1'b0;
    flush_evt    = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          pipe_go = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          wait_d = wait_inc;
          if (wait_inc >= WAIT_LIMIT) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end
        end else begin
          pipe_go = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end
      end
      HALT:    timeout_d = 1'b1;
      default: state_d = RUN;
    endcase

    // The ready cycle of a memory wait is decoded exactly like a free RUN cycle.
    if (pipe_go) begin
      if (ex_branch_taken) begin
        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (hazard) begin
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
      end else begin
        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
      end
    end

    if (!reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_write && (stall_q != CNT_SAT)) stall_d = stall_q + 1'b1;
      if (flush_evt && (flush_q != CNT_SAT)) flush_d = flush_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves, in priority order: data-memory wait stalls, taken-branch flushes, and load-use hazards.
- Keeps saturating performance counters and a memory-wait watchdog.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- WAIT_MAX, 64, maximum consecutive memory-wait cycles before timeout (>=1).
- WAIT_W, 7, width of the internal wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_write  out  1  ID/EX load enable.
- ex_mem_write  out  1  EX/MEM and MEM/WB load enable.
- if_id_flush  out  1  IF/ID load-zero (NOP).
- id_ex_flush  out  1  ID/EX load-zero (bubble).
- mem_timeout  out  1  sticky watchdog flag.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  number of branch flushes.

Behaviour:
- States: RUN, MEM_WAIT, HALT. State is held in registers; control outputs are a combinational decode of state and current inputs.
- Reset (reset=0, asynchronous):
  - state=RUN, wait counter=0, stall_count=0, flush_count=0, mem_timeout=0.
  - While reset is low, all write enables and all flushes are forced to 0.
- hazard definition: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). x0 never causes a stall.
- RUN state:
  - mem_req=1 && mem_ready=0:
    - All four write enables = 0; no flush.
    - Next state MEM_WAIT, wait counter=1.
    - Takes priority over branch and hazard in the same cycle.
  - Else if ex_branch_taken=1:
    - All write enables = 1; if_id_flush=1 and id_ex_flush=1.
    - flush_count increments. The branch overrides any load-use hazard, because the ID instruction is discarded.
  - Else if hazard:
    - pc_write=0 and if_id_write=0.
    - id_ex_write=1 with id_ex_flush=1, inserting a bubble; ex_mem_write=1.
    - Exactly one cycle, with no state change; the hazard clears naturally when the load advances.
  - Else: all write enables = 1, no flush.
- MEM_WAIT state:
  - mem_ready=0:
    - All write enables = 0; wait counter increments.
    - If the wait counter reaches WAIT_MAX, go to HALT and set mem_timeout=1.
  - mem_ready=1:
    - The cycle is decoded exactly like RUN with mem_req treated as satisfied, so a branch or hazard is applied in this cycle.
    - Next state RUN, wait counter=0.
- HALT state:
  - All write enables = 0, no flush, mem_timeout=1.
  - Exit only by reset.
- stall_count:
  - Increments on every clock where pc_write=0 (memory wait, load-use, HALT).
  - Saturates at all-ones.
- flush_count saturates at all-ones.
- cnt_clear=1: both counters load 0 at the next edge; clear wins over a simultaneous increment.
- Reset asserted mid-operation (including in MEM_WAIT or HALT): immediate return to RUN with all registers at their reset values.
- Write enables and flushes are never both requesting conflicting actions: a stage with flush=1 always also has write=1.

Test Plan:
- Reset pulse low for 2 cycles, then release with idle inputs -> all enables 1, flushes 0, counters 0, mem_timeout 0.
- ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle:
  - -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_count=1.
  - Repeat with ex_rd=0 -> no stall.
- ex_branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_write=1, flush_count=1, stall_count unchanged.
- mem_req=1 with mem_ready low for 3 cycles, then high:
  - -> all enables 0 for 3 cycles; on the ready cycle all enables 1.
  - stall_count=3, state returns to RUN.
- mem_req=1, mem_ready held 0 with WAIT_MAX=4 -> HALT after 4 cycles, mem_timeout=1 and sticky; reset clears it.
- Drive stall_count to all-ones with CNT_W=4:
  - -> holds at 15.
  - cnt_clear asserted during a stall -> 0 next cycle.
